cntdn_timer: RTL and testbench

- Loadable down-counter/timer; the counterpart of the team's free-running up-counter with enable/clear.
- Software or an FSM loads a period, starts it, and receives a terminal-count pulse plus a sticky done flag.
- Supports one-shot and auto-reload (periodic tick) modes.
- Sits beside the up-counters in timing/timeout logic; `enable` doubles as a prescaler tick input.

---
 rtl/cntdn_pkg.sv | 14 +
 rtl/cntdn_timer.sv | 117 +++++++++++
 tb/tb_cntdn_timer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cntdn_pkg.sv
// cntdn_pkg: shared types for the loadable down-counter/timer.
//   STATE_W - width of the controller state encoding
//   state_t - controller states: IDLE (waiting), RUN (counting), DONE (one-shot finished)
package cntdn_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cntdn_timer.sv
// cntdn_timer: loadable N-bit down-counter/timer with one-shot and periodic
// auto-reload modes, terminal-count pulse and sticky done flag.
//   clk       - rising-edge clock
//   res_n     - asynchronous active-low reset
//   load_val  - period value, captured when load=1
//   load      - write load_val into the period register and the counter
//   start     - begin a countdown from the period register (ignored in RUN)
//   enable    - count-step qualifier / prescaler tick
//   clear     - synchronous abort back to IDLE, period retained
//   reload_en - 1 = periodic auto-reload, 0 = one-shot (sampled at terminal)
//   cnt_out   - current count
//   busy      - high while in RUN
//   tc        - one-cycle pulse following a terminal event
//   done      - high while in DONE
module cntdn_timer
  import cntdn_pkg::*;
#(
  parameter int unsigned N = 10
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic [N-1:0] load_val,
  input  logic         load,
  input  logic         start,
  input  logic         enable,
  input  logic         clear,
  input  logic         reload_en,
  output logic [N-1:0] cnt_out,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] period_q, period_d;
  logic         tc_q, tc_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic; priority clear > load > start > enable-step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    tc_d     = 1'b0;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (load) begin
      state_d  = IDLE;
      period_d = load_val;
      cnt_d    = load_val;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (period_q != '0) begin
              state_d = RUN;
              cnt_d   = period_q;
            end else begin
              // Zero-length run terminates immediately.
              state_d = DONE;
              cnt_d   = '0;
              tc_d    = 1'b1;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (cnt_q > ONE) begin
              cnt_d = cnt_q - ONE;
            end else if (reload_en) begin
              // Reload instead of passing through 0 so the tick period
              // equals exactly `period` enabled cycles.
              cnt_d = period_q;
              tc_d  = 1'b1;
            end else begin
              state_d = DONE;
              cnt_d   = '0;
              tc_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    cnt_out = cnt_q;
    tc      = tc_q;
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_cntdn_timer.sv
// tb_cntdn_timer: directed and randomized checks of cntdn_timer against a
// behavioural model built from the timer's rules.
module tb_cntdn_timer;

  localparam int unsigned N = 10;
  localparam logic [N-1:0] MAXV = '1;

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic [N-1:0] load_val = '0;
  logic         load = 1'b0, start = 1'b0, enable = 1'b0, clear = 1'b0, reload_en = 1'b0;
  logic [N-1:0] cnt_out;
  logic         busy, tc, done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [N-1:0] m_cnt = '0, m_per = '0;
  logic         m_busy = 1'b0, m_tc = 1'b0, m_done = 1'b0;

  cntdn_timer #(.N(N)) dut (
    .clk(clk), .res_n(res_n), .load_val(load_val), .load(load), .start(start),
    .enable(enable), .clear(clear), .reload_en(reload_en),
    .cnt_out(cnt_out), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = '0; m_per = '0; m_busy = 1'b0; m_tc = 1'b0; m_done = 1'b0;
  endtask

  // Apply one clock edge of the timer's rules to the model.
  task automatic model_update();
    m_tc = 1'b0;
    if (clear) begin
      m_cnt = '0; m_busy = 1'b0; m_done = 1'b0;
    end else if (load) begin
      m_per = load_val; m_cnt = load_val; m_busy = 1'b0; m_done = 1'b0;
    end else if (start && !m_busy) begin
      if (m_per != 0) begin
        m_cnt = m_per; m_busy = 1'b1; m_done = 1'b0;
      end else begin
        m_cnt = '0; m_busy = 1'b0; m_done = 1'b1; m_tc = 1'b1;
      end
    end else if (m_busy && enable) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else if (reload_en) begin m_cnt = m_per; m_tc = 1'b1; end
      else begin m_cnt = '0; m_busy = 1'b0; m_done = 1'b1; m_tc = 1'b1; end
    end
  endtask

  task automatic drive(input logic cl, input logic ld, input logic [N-1:0] lv,
                       input logic st, input logic en, input logic re);
    clear = cl; load = ld; load_val = lv; start = st; enable = en; reload_en = re;
  endtask

  // Advance one edge; inputs are stable here, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    if ({cnt_out, busy, tc, done} !== {{N{1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL reset_init: got cnt=%0d busy=%b tc=%b done=%b, want all 0", cnt_out, busy, tc, done);
    end
    n_cmp++;
    @(posedge clk); #1;
    res_n = 1'b1;
    model_reset();
    drive(0, 1, 10'd5, 0, 0, 0); tick();
    drive(0, 0, '0, 1, 0, 0);    tick();
    drive(0, 0, '0, 0, 1, 0);    tick(); tick();
    if (cnt_out !== 10'd3 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prerun: got cnt=%0d busy=%b, want cnt=3 busy=1", cnt_out, busy);
    end
    n_cmp++;
    #2 res_n = 1'b0;
    model_reset();
    #1;
    if ({cnt_out, busy, tc, done} !== {{N{1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL reset_async: got cnt=%0d busy=%b tc=%b done=%b, want all 0", cnt_out, busy, tc, done);
    end
    n_cmp++;
    tick();
    res_n = 1'b1;
    drive(0, 0, '0, 0, 1, 0); tick();
    if ({cnt_out, busy, tc, done} !== {{N{1'b0}}, 3'b000}) begin
      n_err++;
      $display("FAIL reset_after: got cnt=%0d busy=%b tc=%b done=%b, want all 0", cnt_out, busy, tc, done);
    end
    n_cmp++;
  endtask

  task automatic test_oneshot();
    int tcs = 0;
    drive(0, 1, 10'd3, 0, 0, 0); tick();
    drive(0, 0, '0, 1, 0, 0);    tick();
    drive(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tc) tcs++;
      if ({cnt_out, busy, tc, done} !== {m_cnt, m_busy, m_tc, m_done}) begin
        n_err++;
        $display("FAIL oneshot[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                 i, cnt_out, busy, tc, done, m_cnt, m_busy, m_tc, m_done);
      end
      n_cmp++;
      if (i == 2 && {cnt_out, busy, tc, done} !== {10'd0, 3'b011}) begin
        n_err++;
        $display("FAIL oneshot_term: got cnt=%0d busy=%b tc=%b done=%b, want cnt=0 busy=0 tc=1 done=1",
                 cnt_out, busy, tc, done);
      end
      if (i == 2) n_cmp++;
    end
    if (tcs != 1) begin
      n_err++;
      $display("FAIL oneshot_tc_count: got %0d, want 1", tcs);
    end
    n_cmp++;
  endtask

  task automatic test_periodic();
    int tcs = 0, ens = 0;
    drive(0, 1, 10'd4, 0, 0, 1); tick();
    drive(0, 0, '0, 1, 0, 1);    tick();
    for (int i = 0; i < 24; i++) begin
      drive(0, 0, '0, 0, (i % 2 == 0), 1);
      if (enable) ens++;
      tick();
      if (tc) tcs++;
      if ({cnt_out, busy, tc, done} !== {m_cnt, m_busy, m_tc, m_done}) begin
        n_err++;
        $display("FAIL periodic[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                 i, cnt_out, busy, tc, done, m_cnt, m_busy, m_tc, m_done);
      end
      n_cmp++;
    end
    if (tcs != ens / 4) begin
      n_err++;
      $display("FAIL periodic_tc_count: got %0d, want %0d", tcs, ens / 4);
    end
    n_cmp++;
  endtask

  task automatic test_priority();
    drive(0, 1, 10'd2, 0, 0, 0); tick();
    drive(0, 0, '0, 1, 0, 0);    tick();
    drive(0, 0, '0, 0, 1, 0);    tick();
    drive(1, 1, 10'd9, 0, 1, 0); tick();
    if ({cnt_out, busy, tc, done} !== {10'd0, 3'b000}) begin
      n_err++;
      $display("FAIL prio_clear: got cnt=%0d busy=%b tc=%b done=%b, want cnt=0 busy=0 tc=0 done=0",
               cnt_out, busy, tc, done);
    end
    n_cmp++;
    drive(0, 1, 10'd7, 0, 0, 0); tick();
    drive(0, 0, '0, 1, 0, 0);    tick();
    if ({cnt_out, busy, tc, done} !== {10'd7, 3'b100} || cnt_out !== m_cnt) begin
      n_err++;
      $display("FAIL prio_load7: got cnt=%0d busy=%b tc=%b done=%b, want cnt=7 busy=1 tc=0 done=0",
               cnt_out, busy, tc, done);
    end
    n_cmp++;
    // Load during the terminal cycle wins over the terminal event.
    drive(0, 1, 10'd1, 0, 0, 0); tick();
    drive(0, 0, '0, 1, 0, 0);    tick();
    drive(0, 1, 10'd5, 0, 1, 0); tick();
    if ({cnt_out, busy, tc, done} !== {10'd5, 3'b000}) begin
      n_err++;
      $display("FAIL load_terminal: got cnt=%0d busy=%b tc=%b done=%b, want cnt=5 busy=0 tc=0 done=0",
               cnt_out, busy, tc, done);
    end
    n_cmp++;
  endtask

  task automatic test_zero_one();
    drive(0, 1, 10'd0, 0, 0, 0); tick();
    drive(0, 0, '0, 1, 0, 0);    tick();
    if ({cnt_out, busy, tc, done} !== {10'd0, 3'b011}) begin
      n_err++;
      $display("FAIL zero_period: got cnt=%0d busy=%b tc=%b done=%b, want cnt=0 busy=0 tc=1 done=1",
               cnt_out, busy, tc, done);
    end
    n_cmp++;
    drive(0, 1, 10'd1, 0, 0, 1); tick();
    drive(0, 0, '0, 1, 0, 1);    tick();
    drive(0, 0, '0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({cnt_out, busy, tc, done} !== {10'd1, 3'b110}) begin
        n_err++;
        $display("FAIL one_period[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=1 busy=1 tc=1 done=0",
                 i, cnt_out, busy, tc, done);
      end
      n_cmp++;
    end
  endtask

  task automatic test_start_ignored();
    drive(0, 1, 10'd6, 0, 0, 0); tick();
    drive(0, 0, '0, 1, 0, 0);    tick();
    drive(0, 0, '0, 0, 1, 0);    tick(); tick();
    drive(0, 0, '0, 1, 0, 0);    tick();
    drive(0, 0, '0, 0, 1, 0);    tick();
    if (cnt_out !== 10'd3 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_in_run: got cnt=%0d busy=%b, want cnt=3 busy=1", cnt_out, busy);
    end
    n_cmp++;
    for (int i = 0; i < 8 && !done; i++) tick();
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL reach_done: got done=%b, want 1 within 8 cycles", done);
    end
    n_cmp++;
    drive(0, 0, '0, 1, 0, 0); tick();
    if ({cnt_out, busy, tc, done} !== {10'd6, 3'b100}) begin
      n_err++;
      $display("FAIL restart_done: got cnt=%0d busy=%b tc=%b done=%b, want cnt=6 busy=1 tc=0 done=0",
               cnt_out, busy, tc, done);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    logic [N-1:0] lv;
    logic re = 1'b0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: lv = '0;
        1: lv = 10'd1;
        2: lv = 10'd2;
        3: lv = MAXV;
        default: lv = N'($urandom_range(0, 12));
      endcase
      if ($urandom_range(0, 19) == 0) re = ~re;
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0, lv,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, re);
      tick();
      if ({cnt_out, busy, tc, done} !== {m_cnt, m_busy, m_tc, m_done}) begin
        n_err++;
        $display("FAIL random[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                 i, cnt_out, busy, tc, done, m_cnt, m_busy, m_tc, m_done);
      end
      n_cmp++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_priority();
    test_zero_one();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
